// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared types and constants for the parametrised serial
//                transmitter: FSM state encoding, idle line level and a
//                counter-width helper that never yields a 0-width vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_t;

    localparam logic SERIAL_IDLE_LVL = 1'b1;

    // Width of a counter that must hold 0..n-1; at least one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : serial_baud_tick
//  Description : Baud divider. Counts clocks within one serial bit and
//                strobes bit_end on the last clock of each bit. The count
//                restarts on clear (frame accept) and after every bit_end.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_baud_tick
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int               CNT_W    = clog2_min1(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Clock-within-bit counter; restarts on clear and at the end of each bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear || bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // With one clock per bit the counter stays at 0 and this fires every clock
    assign bit_end = (r_cnt == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/serial_tx_param.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx_param
//  Description : UART-style serial framer. Start bit, DATA_W data bits LSB
//                first, optional parity bit, STOP_BITS stop bits; each bit is
//                held CLKS_PER_BIT clocks. valid/ready on the parallel side,
//                all outputs registered.
//                Optional feature macro: SERIAL_TX_PARITY_EN inserts a parity
//                bit (^data ^ PARITY_ODD) after the data bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_tx_param
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              serial,
    output logic              busy_out
);

    localparam int BIT_W  = clog2_min1(DATA_W);
    localparam int STOP_W = clog2_min1(STOP_BITS);

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

    // Elaboration-time guard on the supported parameter ranges
    if (DATA_W < 2 || DATA_W > 16 || CLKS_PER_BIT < 1 ||
        STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("serial_tx_param: parameter out of supported range");
    end

    tx_state_t          r_state;
    tx_state_t          w_state_nxt;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  w_shift_nxt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [STOP_W-1:0]  r_stop_cnt;
    logic               r_serial;
    logic               r_busy;
    logic               r_ready;
    logic               w_serial_nxt;
    logic               w_busy_nxt;
    logic               w_ready_nxt;
    logic               w_bit_end;
    logic               w_accept;
    logic               w_last_bit;
    logic               w_last_stop;

`ifdef SERIAL_TX_PARITY_EN
    logic               r_parity;
`endif

    // A word is taken only while idle and advertising ready
    assign w_accept    = valid_in && r_ready && (r_state == S_IDLE);
    assign w_last_bit  = (r_bit_cnt == BIT_LAST);
    assign w_last_stop = (r_stop_cnt == STOP_LAST);

    serial_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_accept),
        .bit_end (w_bit_end)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: every non-idle state advances on the bit_end strobe
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept)  w_state_nxt = S_START;
            S_START:  if (w_bit_end) w_state_nxt = S_DATA;
            S_DATA: begin
                if (w_bit_end && w_last_bit) begin
`ifdef SERIAL_TX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
`endif
            S_STOP:   if (w_bit_end && w_last_stop) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Shift register next value: load on accept, shift right after each data bit
    always_comb begin
        w_shift_nxt = r_shift;
        if (w_accept) begin
            w_shift_nxt = data_in;
        end else if (r_state == S_DATA && w_bit_end) begin
            w_shift_nxt = r_shift >> 1;
        end
    end

    // Output logic: registered outputs follow the state being entered
    always_comb begin
        w_serial_nxt = SERIAL_IDLE_LVL;
        w_busy_nxt   = 1'b1;
        w_ready_nxt  = 1'b0;
        case (w_state_nxt)
            S_IDLE: begin
                w_busy_nxt  = 1'b0;
                w_ready_nxt = 1'b1;
            end
            S_START:  w_serial_nxt = 1'b0;
            S_DATA:   w_serial_nxt = w_shift_nxt[0];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: w_serial_nxt = r_parity;
`endif
            default:  w_serial_nxt = SERIAL_IDLE_LVL;
        endcase
    end

    // Datapath and output registers; reset aborts any frame in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_serial   <= SERIAL_IDLE_LVL;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_shift  <= w_shift_nxt;
            r_serial <= w_serial_nxt;
            r_busy   <= w_busy_nxt;
            r_ready  <= w_ready_nxt;
            if (w_accept) begin
                r_bit_cnt  <= '0;
                r_stop_cnt <= '0;
            end else if (w_bit_end) begin
                if (r_state == S_DATA) r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
                if (r_state == S_STOP) r_stop_cnt <= r_stop_cnt + STOP_W'(1);
            end
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    // Parity of the word latched at accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= (^data_in) ^ (PARITY_ODD != 0);
        end
    end
`endif

    assign serial    = r_serial;
    assign busy_out  = r_busy;
    assign ready_out = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_tx_param
//  Description : Self-checking bench for serial_tx_param. Four instances with
//                different parameter sets; expected per-clock line/busy/ready
//                values are queued when a word is offered and popped as the
//                selected instance runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx_param;

`ifdef SERIAL_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    // Instance table: 0 = 8b/cpb4/1stop/even, 1 = odd, 2 = 2 stop, 3 = 4b/cpb1
    int dw_t   [4] = '{8, 8, 8, 4};
    int cpb_t  [4] = '{4, 4, 4, 1};
    int stop_t [4] = '{1, 1, 2, 1};
    bit odd_t  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    typedef struct packed {
        logic ser;
        logic bsy;
        logic rdy;
    } exp_t;

    exp_t exp_q[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] dat_a, dat_p, dat_b;
    logic [3:0] dat_c;
    logic [3:0] vld;
    wire  [3:0] ser, bsy, rdy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
        .clk(clk), .rst(rst_n), .data_in(dat_a), .valid_in(vld[0]),
        .ready_out(rdy[0]), .serial(ser[0]), .busy_out(bsy[0]));

    serial_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(1)) u_p (
        .clk(clk), .rst(rst_n), .data_in(dat_p), .valid_in(vld[1]),
        .ready_out(rdy[1]), .serial(ser[1]), .busy_out(bsy[1]));

    serial_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_ODD(0)) u_b (
        .clk(clk), .rst(rst_n), .data_in(dat_b), .valid_in(vld[2]),
        .ready_out(rdy[2]), .serial(ser[2]), .busy_out(bsy[2]));

    serial_tx_param #(.DATA_W(4), .CLKS_PER_BIT(1), .STOP_BITS(1), .PARITY_ODD(0)) u_c (
        .clk(clk), .rst(rst_n), .data_in(dat_c), .valid_in(vld[3]),
        .ready_out(rdy[3]), .serial(ser[3]), .busy_out(bsy[3]));

    function automatic int frame_len(input int idx);
        return (1 + dw_t[idx] + int'(PAR_EN) + stop_t[idx]) * cpb_t[idx];
    endfunction

    function automatic void push_one(input logic s, input logic b, input logic r);
        exp_t e;
        e.ser = s;
        e.bsy = b;
        e.rdy = r;
        exp_q.push_back(e);
    endfunction

    // Expected line per clock for one frame: start, data LSB first, parity, stop
    function automatic void push_frame(input int idx, input logic [15:0] w);
        logic p;
        p = odd_t[idx];
        for (int c = 0; c < cpb_t[idx]; c++) push_one(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < dw_t[idx]; i++) begin
            p = p ^ w[i];
            for (int c = 0; c < cpb_t[idx]; c++) push_one(w[i], 1'b1, 1'b0);
        end
        if (PAR_EN) begin
            for (int c = 0; c < cpb_t[idx]; c++) push_one(p, 1'b1, 1'b0);
        end
        for (int c = 0; c < stop_t[idx] * cpb_t[idx]; c++) push_one(1'b1, 1'b1, 1'b0);
    endfunction

    function automatic void push_idle(input int n);
        for (int i = 0; i < n; i++) push_one(1'b1, 1'b0, 1'b1);
    endfunction

    task automatic set_data(input int idx, input logic [15:0] w);
        case (idx)
            0:       dat_a = w[7:0];
            1:       dat_p = w[7:0];
            2:       dat_b = w[7:0];
            default: dat_c = w[3:0];
        endcase
    endtask

    task automatic wait_ready(input int idx);
        int n;
        n = 0;
        while (rdy[idx] !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (rdy[idx] !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL wait_ready[%0d]: ready_out=%b after %0d clk, required 1", idx, rdy[idx], n);
        end
    endtask

    // Pop the scoreboard one clock at a time; swap data after the accept edge
    // and drop valid after sample drop_at
    task automatic check_stream(input int idx, input string name, input int drop_at,
                                input logic [15:0] swap_word);
        exp_t e;
        int   k;
        k = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests++;
            if ({ser[idx], bsy[idx], rdy[idx]} !== e) begin
                fails++;
                $display("FAIL %s[%0d]: serial/busy/ready=%b%b%b required %b%b%b",
                         name, k, ser[idx], bsy[idx], rdy[idx], e.ser, e.bsy, e.rdy);
            end
            if (k == 0)       set_data(idx, swap_word);
            if (k == drop_at) vld[idx] = 1'b0;
            k++;
        end
    endtask

    task automatic send_frame(input int idx, input logic [15:0] w, input string name);
        wait_ready(idx);
        set_data(idx, w);
        vld[idx] = 1'b1;
        exp_q.delete();
        push_frame(idx, w);
        push_idle(2);
        check_stream(idx, name, 0, ~w);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({ser[i], bsy[i], rdy[i]} !== 3'b100) begin
                fails++;
                $display("FAIL reset_state[%0d]: serial/busy/ready=%b%b%b required 100", i, ser[i], bsy[i], rdy[i]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({ser[i], bsy[i], rdy[i]} !== 3'b101) begin
                fails++;
                $display("FAIL reset_release[%0d]: serial/busy/ready=%b%b%b required 101", i, ser[i], bsy[i], rdy[i]);
            end
        end
    endtask

    task automatic test_basic();
        send_frame(0, 16'h00A5, "basic_a5");
        send_frame(0, 16'h0000, "basic_00");
        send_frame(0, 16'h00FF, "basic_ff");
        send_frame(0, 16'($urandom_range(0, 255)), "basic_rand0");
        send_frame(0, 16'($urandom_range(0, 255)), "basic_rand1");
    endtask

    task automatic test_back_to_back();
        wait_ready(0);
        set_data(0, 16'h0001);
        vld[0] = 1'b1;
        exp_q.delete();
        push_frame(0, 16'h0001);
        push_one(1'b1, 1'b0, 1'b1);
        push_frame(0, 16'h00FF);
        push_idle(2);
        check_stream(0, "b2b", frame_len(0) + 1, 16'h00FF);
    endtask

    task automatic test_parity();
        send_frame(0, 16'h0007, "parity_even_07");
        send_frame(1, 16'h0007, "parity_odd_07");
        send_frame(1, 16'h00C3, "parity_odd_c3");
    endtask

    task automatic test_stop2();
        send_frame(2, 16'h0000, "stop2_00");
        send_frame(2, 16'h0081, "stop2_81");
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        wait_ready(0);
        set_data(0, 16'h0052);
        vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        // Sample 17 lies in data bit 3, which is 0 for 0x52
        tests++;
        if ({ser[0], bsy[0]} !== 2'b01) begin
            fails++;
            $display("FAIL mid_frame_bit3: serial/busy=%b%b required 01", ser[0], bsy[0]);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({ser[0], bsy[0], rdy[0]} !== 3'b100) begin
            fails++;
            $display("FAIL async_abort: serial/busy/ready=%b%b%b required 100", ser[0], bsy[0], rdy[0]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests++;
        if (rdy[0] !== 1'b0) begin
            fails++;
            $display("FAIL ready_at_release: ready_out=%b required 0", rdy[0]);
        end
        @(posedge clk); #1;
        tests++;
        if ({ser[0], bsy[0], rdy[0]} !== 3'b101) begin
            fails++;
            $display("FAIL ready_after_release: serial/busy/ready=%b%b%b required 101", ser[0], bsy[0], rdy[0]);
        end
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bsy[0] !== 1'b0 || ser[0] !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL no_retransmit: %0d non-idle clocks required 0", bad);
        end
        send_frame(0, 16'h003C, "after_reset_3c");
    endtask

    task automatic test_cpb1();
        send_frame(3, 16'h0009, "cpb1_9");
        send_frame(3, 16'h0006, "cpb1_6");
    endtask

    initial begin
        rst_n = 1'b0;
        vld   = 4'b0000;
        dat_a = 8'h00;
        dat_p = 8'h00;
        dat_b = 8'h00;
        dat_c = 4'h0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_parity();
        test_stop2();
        test_reset_mid_frame();
        test_cpb1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
